// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite command path:
// command-word layout, info/type codes, scheduler states.
package sprite_pkg;

  localparam int SUB_COMP_LO = 26;
  localparam int CHILD_LO    = 21;
  localparam int INFO_LO     = 17;
  localparam int TYPE_LO     = 14;
  localparam int PP_SEL_BIT  = 13;
  localparam int MSG_LO      = 0;

  localparam logic [3:0] INFO_NOP   = 4'h0;
  localparam logic [3:0] INFO_WRITE = 4'h1;
  localparam logic [3:0] INFO_FLIP  = 4'hF;

  localparam logic [2:0] TYPE_SPRITE = 3'd0;
  localparam logic [2:0] TYPE_POS    = 3'd1;
  localparam logic [2:0] TYPE_ATTR   = 3'd2;
  localparam logic [2:0] TYPE_VIS    = 3'd3;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_COMMIT = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    DRAIN   = 2'd0,
    WAIT_VB = 2'd1,
    FLIP    = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic        tag;
    logic [31:0] word;
  } fifo_entry_t;

  // Route a command into the hidden buffer at drain time.
  function automatic logic [31:0] steer_back(
    input logic [31:0] w,
    input logic        front
  );
    logic [31:0] r;
    r             = w;
    r[PP_SEL_BIT] = ~front;
    return r;
  endfunction

endpackage

// File: rtl/sprite_cmd_fifo.sv
// First-word-fall-through command FIFO with
// full/empty/level flags and async reset.
module sprite_cmd_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 33,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Drains queued sprite commands into the back buffer and
// flips front/back only at the start of vertical blanking.
module sprite_frame_scheduler
  import sprite_pkg::*;
#(
  parameter int         DEPTH       = 64,
  parameter logic [9:0] VBLANK_LINE = 10'd480,
  parameter logic [3:0] FLIP_INFO   = 4'b1111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] PEND_MAX = DEPTH[LW-1:0];

  fifo_entry_t   push_entry;
  fifo_entry_t   head;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;

  sched_state_t  state;
  logic          front_buf;
  logic [15:0]   frame_cnt;
  logic [LW-1:0] pending;
  logic [9:0]    vcount_q;
  logic          vb_edge;

  logic          wr_cmd;
  logic          wr_commit;
  logic          mk_push;
  logic          mk_pop;
  logic [31:0]   flip_cmd;
  logic [4:0]    pending_lo;
  logic [7:0]    level_lo;
  logic          unused_hcount;

  assign unused_hcount = ^hcount;

  assign wr_cmd    = chipselect && write && (address == ADDR_CMD);
  assign wr_commit = chipselect && write && (address == ADDR_COMMIT);
  assign push      = (wr_cmd || wr_commit) && !full;
  assign pop       = (state == DRAIN) && !empty;

  assign push_entry = wr_commit
    ? fifo_entry_t'{tag: 1'b1, word: 32'h0}
    : fifo_entry_t'{tag: 1'b0, word: writedata};

  assign waitrequest = full;

  sprite_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign vb_edge = (vcount == VBLANK_LINE) &&
                   (vcount_q != VBLANK_LINE);

  assign flip_cmd = {6'h0, 5'h0, FLIP_INFO, 3'b000,
                     ~front_buf, 13'h0};

  assign mk_push = push && wr_commit;
  assign mk_pop  = pop && head.tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      unique case ({mk_push, mk_pop})
        2'b10: begin
          if (pending != PEND_MAX) pending <= pending + 1'b1;
        end
        2'b01: begin
          if (pending != '0) pending <= pending - 1'b1;
        end
        default: pending <= pending;
      endcase
    end
  end

  // cmd_out is a register: a popped word appears the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= DRAIN;
      front_buf <= 1'b0;
      frame_cnt <= 16'h0;
      cmd_out   <= 32'h0;
      vcount_q  <= 10'h0;
    end else begin
      vcount_q <= vcount;
      cmd_out  <= 32'h0;
      unique case (state)
        DRAIN: begin
          if (!empty) begin
            if (head.tag) state <= WAIT_VB;
            else cmd_out <= steer_back(head.word, front_buf);
          end
        end
        WAIT_VB: begin
          if (vb_edge) begin
            state   <= FLIP;
            cmd_out <= flip_cmd;
          end
        end
        FLIP: begin
          front_buf <= ~front_buf;
          frame_cnt <= frame_cnt + 16'h1;
          state     <= DRAIN;
        end
        default: state <= DRAIN;
      endcase
    end
  end

  assign pending_lo = 5'(pending);
  assign level_lo   = 8'(level);

  assign readdata =
    (read && chipselect && (address == ADDR_STATUS))
      ? {frame_cnt, front_buf, state, pending_lo, level_lo}
      : 32'h0;

endmodule
